// File: rtl/safe_softmax_pkg.sv
// Shared constants and FSM state type for the safe-softmax exponent stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package safe_softmax_pkg;

    localparam logic [13:0] LOG2E_Q13 = 14'd11819;  // log2(e) in Q13
    localparam logic [13:0] ONE_Q13   = 14'd8192;   // 1.0 in Q13
    localparam int          LUT_IDX_W = 5;          // fractional index bits into the 2^-f table
    localparam int          LUT_W     = 14;         // table entry width (holds 8192)
    localparam int          FRAC_W    = 13;         // fractional bits of the Q13 formats
    localparam int          MAX_SHIFT = 14;         // integer exponent at which the result flushes to 0

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/safe_softmax_lut_neg.sv
// 2^(-vi/32) lookup in Q13 (8192 = 1.0), rounded to nearest.
// Latency: combinational.
// Backpressure: none (pure function of vi).
module safe_softmax_lut_neg
    import safe_softmax_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] vi,
    output logic [LUT_W-1:0]     val
);

    // Table lookup of the fractional power of two
    always_comb begin
        val = ONE_Q13;
        case (vi)
            5'd0:    val = ONE_Q13;
            5'd1:    val = 14'd8016;
            5'd2:    val = 14'd7845;
            5'd3:    val = 14'd7677;
            5'd4:    val = 14'd7512;
            5'd5:    val = 14'd7351;
            5'd6:    val = 14'd7194;
            5'd7:    val = 14'd7039;
            5'd8:    val = 14'd6889;
            5'd9:    val = 14'd6741;
            5'd10:   val = 14'd6597;
            5'd11:   val = 14'd6455;
            5'd12:   val = 14'd6317;
            5'd13:   val = 14'd6182;
            5'd14:   val = 14'd6049;
            5'd15:   val = 14'd5919;
            5'd16:   val = 14'd5793;
            5'd17:   val = 14'd5668;
            5'd18:   val = 14'd5547;
            5'd19:   val = 14'd5428;
            5'd20:   val = 14'd5312;
            5'd21:   val = 14'd5198;
            5'd22:   val = 14'd5087;
            5'd23:   val = 14'd4978;
            5'd24:   val = 14'd4871;
            5'd25:   val = 14'd4767;
            5'd26:   val = 14'd4664;
            5'd27:   val = 14'd4565;
            5'd28:   val = 14'd4467;
            5'd29:   val = 14'd4371;
            5'd30:   val = 14'd4277;
            5'd31:   val = 14'd4186;
            default: val = ONE_Q13;
        endcase
    end

endmodule

// File: rtl/safe_softmax_exp_stage.sv
// Buffers one row of scores, tracks its max, then streams exp(x - max) = 2^-(d*log2e) per element.
// Latency: first result 2 cycles after the last accepted score, then 1 result/cycle.
// Backpressure: o_ready low for the whole output phase; o_data/o_last held while o_valid & !i_ready.
// Optional row-sum output o_sum is built only when SOFTMAX_SUM_EN is defined.
module safe_softmax_exp_stage
    import safe_softmax_pkg::*;
#(
    parameter int D_W     = 16,
    parameter int ROW_LEN = 16
)(
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [D_W-1:0]                  i_data,
    input  logic                            i_valid,
    output logic                            o_ready,
    output logic [D_W-1:0]                  o_data,
    output logic                            o_valid,
    output logic                            o_last,
    input  logic                            i_ready,
    output logic [D_W+$clog2(ROW_LEN)-1:0]  o_sum
);

    localparam int CNT_W  = $clog2(ROW_LEN);
    localparam int SUM_W  = D_W + CNT_W;
    localparam int PROD_W = D_W + 1 + $bits(LOG2E_Q13);
    localparam int T_W    = PROD_W - FRAC_W;
    localparam int K_W    = T_W - FRAC_W;
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(ROW_LEN - 1);
    localparam logic signed [D_W-1:0] MOST_NEG = {1'b1, {(D_W-1){1'b0}}};

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      wcnt, rcnt;
    logic signed [D_W-1:0] row_max;
    logic [D_W-1:0]        row_buf [ROW_LEN];
    logic                  accept, load_out;
    logic [D_W-1:0]        x_cur;
    logic [D_W:0]          diff;
    logic [PROD_W-1:0]     prod;
    logic [T_W-1:0]        t;
    logic [K_W-1:0]        k;
    logic [LUT_IDX_W-1:0]  vi;
    logic [LUT_W-1:0]      lut_val;
    logic [D_W-1:0]        y;

    assign accept = i_valid & o_ready;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= LOAD;
        else       state <= state_nxt;
    end

    // Next state, input ready and output-register load enable
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        load_out  = 1'b0;
        case (state)
            LOAD: begin
                o_ready = 1'b1;
                if (i_valid && wcnt == LAST_IDX) state_nxt = CALC;
            end
            CALC: begin
                if (!o_valid || i_ready) begin
                    load_out = 1'b1;
                    if (rcnt == LAST_IDX) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (o_valid && i_ready) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Row buffer: plain register array written in arrival order
    always_ff @(posedge i_clk) begin
        if (accept) row_buf[wcnt] <= i_data;
    end

    // d is never negative since max >= every element; one extra bit covers the full signed span
    assign x_cur = row_buf[rcnt];
    assign diff  = {row_max[D_W-1], row_max} - {x_cur[D_W-1], x_cur};
    assign prod  = PROD_W'(diff) * PROD_W'(LOG2E_Q13);
    assign t     = T_W'(prod >> FRAC_W);
    assign k     = K_W'(t >> FRAC_W);
    assign vi    = LUT_IDX_W'(t >> (FRAC_W - LUT_IDX_W));
    assign y     = (k >= K_W'(MAX_SHIFT)) ? '0 : (D_W'(lut_val) >> k);

    safe_softmax_lut_neg u_lut (
        .vi  (vi),
        .val (lut_val)
    );

    // Counters, running max and the output register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wcnt    <= '0;
            rcnt    <= '0;
            row_max <= MOST_NEG;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else begin
            if (accept) begin
                wcnt <= (wcnt == LAST_IDX) ? '0 : wcnt + 1'b1;
                if ($signed(i_data) > row_max) row_max <= $signed(i_data);
                if (wcnt == LAST_IDX) rcnt <= '0;
            end
            if (load_out) begin
                o_data  <= y;
                o_last  <= (rcnt == LAST_IDX);
                o_valid <= 1'b1;
                rcnt    <= rcnt + 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
            if (state == DRAIN && state_nxt == LOAD) begin
                wcnt    <= '0;
                row_max <= MOST_NEG;
            end
        end
    end

`ifdef SOFTMAX_SUM_EN
    logic [SUM_W-1:0] sum_acc;

    // Row sum: cleared as the row enters CALC, then adds every result loaded into the output register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                            sum_acc <= '0;
        else if (accept && wcnt == LAST_IDX)  sum_acc <= '0;
        else if (load_out)                    sum_acc <= sum_acc + SUM_W'(y);
    end

    assign o_sum = sum_acc;
`else
    assign o_sum = '0;
`endif

endmodule

// File: tb/tb_safe_softmax_exp_stage.sv
// Directed bench for safe_softmax_exp_stage: hand-computed rows, backpressure and reset cases.
// Latency: n/a.
// Backpressure: driven by the bench through i_ready.
module tb_safe_softmax_exp_stage;

    localparam int D_W     = 16;
    localparam int ROW_LEN = 16;
    localparam int SUM_W   = D_W + $clog2(ROW_LEN);

`ifdef SOFTMAX_SUM_EN
    localparam logic SUM_ON = 1'b1;
`else
    localparam logic SUM_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             i_rst;
    logic [D_W-1:0]   i_data;
    logic             i_valid;
    logic             o_ready;
    logic [D_W-1:0]   o_data;
    logic             o_valid;
    logic             o_last;
    logic             i_ready;
    logic [SUM_W-1:0] o_sum;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [D_W-1:0]   row_v      [ROW_LEN];
    logic [D_W-1:0]   out_dat    [ROW_LEN];
    logic             out_last_a [ROW_LEN];
    logic [SUM_W-1:0] out_sum_a  [ROW_LEN];
    int               got;
    int               coll_cycles;

    always #5 clk = ~clk;

    safe_softmax_exp_stage #(.D_W(D_W), .ROW_LEN(ROW_LEN)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_last  (o_last),
        .i_ready (i_ready),
        .o_sum   (o_sum)
    );

    // Present n scores from row_v, one per cycle; called at a negedge while in LOAD
    task automatic send_row(input int n);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_data  = row_v[i];
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_data  = '0;
    endtask

    // Record up to n output beats with i_ready held high, bounded by a cycle budget
    task automatic collect(input int n);
        got         = 0;
        coll_cycles = 0;
        i_ready     = 1'b1;
        while (got < n && coll_cycles < 200) begin
            if (o_valid) begin
                out_dat[got]    = o_data;
                out_last_a[got] = o_last;
                out_sum_a[got]  = o_sum;
                got++;
            end
            @(negedge clk);
            coll_cycles++;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ctrl got v=%0b l=%0b r=%0b want v=0 l=0 r=1", o_valid, o_last, o_ready);
        end
        tests_run++;
        if (o_data !== 16'd0 || o_sum !== 20'd0) begin
            tests_failed++;
            $display("FAIL reset_data got data=%0d sum=%0d want 0 0", o_data, o_sum);
        end
        i_rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release got r=%0b v=%0b want r=1 v=0", o_ready, o_valid);
        end
    endtask

    task automatic test_equal_row();
        for (int i = 0; i < ROW_LEN; i++) row_v[i] = 16'h1000;
        send_row(ROW_LEN);
        tests_run++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL eq_latency_cycle1 got v=%0b r=%0b want v=0 r=0", o_valid, o_ready);
        end
        @(negedge clk);
        tests_run++;
        if (o_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL eq_latency_cycle2 got v=%0b want 1", o_valid);
        end
        collect(ROW_LEN);
        tests_run++;
        if (got !== ROW_LEN || coll_cycles !== ROW_LEN) begin
            tests_failed++;
            $display("FAIL eq_throughput got %0d beats in %0d cycles want 16 in 16", got, coll_cycles);
        end
        for (int i = 0; i < ROW_LEN; i++) begin
            logic exp_last;
            exp_last = (i == ROW_LEN - 1);
            tests_run++;
            if (out_dat[i] !== 16'd8192 || out_last_a[i] !== exp_last) begin
                tests_failed++;
                $display("FAIL eq_elem[%0d] got data=%0d last=%0b want data=8192 last=%0b", i, out_dat[i], out_last_a[i], exp_last);
            end
        end
        tests_run++;
        if (out_sum_a[ROW_LEN-1] !== (SUM_ON ? 20'd131072 : 20'd0)) begin
            tests_failed++;
            $display("FAIL eq_sum_last_beat got %0d want %0d", out_sum_a[ROW_LEN-1], SUM_ON ? 131072 : 0);
        end
        tests_run++;
        if (o_sum !== (SUM_ON ? 20'd131072 : 20'd0) || o_ready !== 1'b1 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL eq_after_row got sum=%0d r=%0b v=%0b want sum=%0d r=1 v=0", o_sum, o_ready, o_valid, SUM_ON ? 131072 : 0);
        end
    endtask

    task automatic test_step_row();
        row_v[0] = 16'd8192;
        for (int i = 1; i < ROW_LEN; i++) row_v[i] = 16'd0;
        send_row(ROW_LEN);
        collect(ROW_LEN);
        tests_run++;
        if (got !== ROW_LEN) begin
            tests_failed++;
            $display("FAIL step_count got %0d want 16", got);
        end
        for (int i = 0; i < ROW_LEN; i++) begin
            logic [D_W-1:0] exp_d;
            exp_d = (i == 0) ? 16'd8192 : 16'd3024;
            tests_run++;
            if (out_dat[i] !== exp_d) begin
                tests_failed++;
                $display("FAIL step_elem[%0d] got %0d want %0d", i, out_dat[i], exp_d);
            end
        end
        tests_run++;
        if (out_sum_a[ROW_LEN-1] !== (SUM_ON ? 20'd53552 : 20'd0)) begin
            tests_failed++;
            $display("FAIL step_sum got %0d want %0d", out_sum_a[ROW_LEN-1], SUM_ON ? 53552 : 0);
        end
    endtask

    task automatic test_extreme_row();
        for (int i = 0; i < ROW_LEN; i++) row_v[i] = 16'h7FFF;
        row_v[1] = 16'h8000;
        send_row(ROW_LEN);
        collect(ROW_LEN);
        tests_run++;
        if (got !== ROW_LEN) begin
            tests_failed++;
            $display("FAIL ext_count got %0d want 16", got);
        end
        for (int i = 0; i < ROW_LEN; i++) begin
            logic [D_W-1:0] exp_d;
            exp_d = (i == 1) ? 16'd2 : 16'd8192;
            tests_run++;
            if (out_dat[i] !== exp_d) begin
                tests_failed++;
                $display("FAIL ext_elem[%0d] got %0d want %0d", i, out_dat[i], exp_d);
            end
        end
        tests_run++;
        if (out_sum_a[ROW_LEN-1] !== (SUM_ON ? 20'd122882 : 20'd0)) begin
            tests_failed++;
            $display("FAIL ext_sum got %0d want %0d", out_sum_a[ROW_LEN-1], SUM_ON ? 122882 : 0);
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [D_W-1:0] pat [4];
        logic [D_W-1:0] pat_in [4];
        int stall;
        int cyc;
        pat[0] = 16'd8192; pat[1] = 16'd4978; pat[2] = 16'd3024; pat[3] = 16'd56;
        pat_in[0] = 16'd8192; pat_in[1] = 16'd4096; pat_in[2] = 16'd0; pat_in[3] = 16'h8000;
        for (int i = 0; i < ROW_LEN; i++) row_v[i] = pat_in[i % 4];
        send_row(ROW_LEN);
        got = 0; stall = 0; cyc = 0;
        i_ready = 1'b1;
        while (got < ROW_LEN && cyc < 300) begin
            if (got == 5 && stall < 3) begin
                i_ready = 1'b0;
                tests_run++;
                if (o_valid !== 1'b1 || o_data !== 16'd4978 || o_last !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stall_hold[%0d] got v=%0b data=%0d last=%0b want v=1 data=4978 last=0", stall, o_valid, o_data, o_last);
                end
                stall++;
            end else begin
                i_ready = 1'b1;
                if (o_valid) begin
                    out_dat[got]    = o_data;
                    out_last_a[got] = o_last;
                    out_sum_a[got]  = o_sum;
                    got++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        i_ready = 1'b1;
        tests_run++;
        if (got !== ROW_LEN || stall !== 3) begin
            tests_failed++;
            $display("FAIL stall_count got %0d beats %0d stalls want 16 beats 3 stalls", got, stall);
        end
        for (int i = 0; i < ROW_LEN; i++) begin
            logic exp_last;
            exp_last = (i == ROW_LEN - 1);
            tests_run++;
            if (out_dat[i] !== pat[i % 4] || out_last_a[i] !== exp_last) begin
                tests_failed++;
                $display("FAIL stall_elem[%0d] got data=%0d last=%0b want data=%0d last=%0b", i, out_dat[i], out_last_a[i], pat[i % 4], exp_last);
            end
        end
        tests_run++;
        if (out_sum_a[ROW_LEN-1] !== (SUM_ON ? 20'd65000 : 20'd0)) begin
            tests_failed++;
            $display("FAIL stall_sum got %0d want %0d", out_sum_a[ROW_LEN-1], SUM_ON ? 65000 : 0);
        end
    endtask

    task automatic test_midrow_reset();
        for (int i = 0; i < ROW_LEN; i++) row_v[i] = 16'h7FFF;
        send_row(5);
        i_rst = 1'b1;
        #1;
        tests_run++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrow_reset got v=%0b r=%0b want v=0 r=1", o_valid, o_ready);
        end
        @(negedge clk);
        i_rst = 1'b0;
        row_v[0] = 16'd8192;
        for (int i = 1; i < ROW_LEN; i++) row_v[i] = 16'd0;
        send_row(ROW_LEN);
        collect(ROW_LEN);
        tests_run++;
        if (got !== ROW_LEN) begin
            tests_failed++;
            $display("FAIL midrow_count got %0d want 16", got);
        end
        for (int i = 0; i < ROW_LEN; i++) begin
            logic [D_W-1:0] exp_d;
            logic           exp_last;
            exp_d    = (i == 0) ? 16'd8192 : 16'd3024;
            exp_last = (i == ROW_LEN - 1);
            tests_run++;
            if (out_dat[i] !== exp_d || out_last_a[i] !== exp_last) begin
                tests_failed++;
                $display("FAIL midrow_elem[%0d] got data=%0d last=%0b want data=%0d last=%0b", i, out_dat[i], out_last_a[i], exp_d, exp_last);
            end
        end
    endtask

    task automatic test_reset_during_output();
        for (int i = 0; i < ROW_LEN; i++) row_v[i] = 16'h1000;
        send_row(ROW_LEN);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (o_valid !== 1'b1 || o_data !== 16'd8192) begin
            tests_failed++;
            $display("FAIL outrst_pre got v=%0b data=%0d want v=1 data=8192", o_valid, o_data);
        end
        #2;
        i_rst = 1'b1;
        #1;
        tests_run++;
        if (o_valid !== 1'b0 || o_data !== 16'd0 || o_last !== 1'b0 || o_ready !== 1'b1 || o_sum !== 20'd0) begin
            tests_failed++;
            $display("FAIL outrst_async got v=%0b data=%0d last=%0b r=%0b sum=%0d want 0 0 0 1 0", o_valid, o_data, o_last, o_ready, o_sum);
        end
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_equal_row();
        test_step_row();
        test_extreme_row();
        test_back_to_back_stall();
        test_midrow_reset();
        test_reset_during_output();
        test_equal_row();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
